// File: rtl/s_axi_read_pkg.sv
// Shared register-map codes and FSM encoding for the AXI-Lite read and write responders.
package s_axi_read_pkg;

    localparam logic [1:0] BANK_SEL_0 = 2'b00;
    localparam logic [1:0] BANK_SEL_1 = 2'b01;

    localparam logic [7:0] SLOT_CONTROL     = 8'h00;
    localparam logic [7:0] SLOT_STATUS      = 8'h01;
    localparam logic [7:0] SLOT_CNT         = 8'h02;
    localparam logic [7:0] SLOT_END_CNT     = 8'h03;
    localparam logic [7:0] SLOT_DMA_BASE    = 8'h04;
    localparam logic [7:0] SLOT_DFX_CTRL    = 8'h05;
    localparam logic [7:0] SLOT_INTR_ENA    = 8'h06;
    localparam logic [7:0] SLOT_INTR        = 8'h07;
    localparam logic [7:0] SLOT_ROUND_TRIP  = 8'h08;

    // Bank1 fields run contiguously from src_addr to st_intr_mask_abs.
    localparam logic [3:0] FIELD_SRC_ADDR         = 4'd0;
    localparam logic [3:0] FIELD_ST_INTR_MASK_ABS = 4'd8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_CAPT  = 2'd2,
        ST_RESP  = 2'd3
    } read_state_t;

endpackage

// File: rtl/s_axi_read_decode.sv
// Combinational address decode: selects a bank0 register or the bank1 slot-table value.
module s_axi_read_decode
    import s_axi_read_pkg::*;
#(
    parameter int GLOB_ADDR_WIDTH       = 32,
    parameter int ADDR_WIDTH            = 16,
    parameter int DATA_WIDTH            = 32,
    parameter int BANK0_CONTROL_WIDTH   = 4,
    parameter int BANK0_STATUS_WIDTH    = 4,
    parameter int BANK0_CNT_WIDTH       = 3,
    parameter int BANK0_INTR_WIDTH      = 1,
    parameter int BANK0_ROUNDTRIP_WIDTH = 16
) (
    input  logic [ADDR_WIDTH-1:0]            read_addr,
    input  logic [BANK0_CONTROL_WIDTH-1:0]   bank0_control,
    input  logic [BANK0_STATUS_WIDTH-1:0]    bank0_status,
    input  logic [BANK0_CNT_WIDTH-1:0]       bank0_cnt,
    input  logic [BANK0_CNT_WIDTH-1:0]       bank0_end_cnt,
    input  logic [GLOB_ADDR_WIDTH-1:0]       bank0_dma_base_addr,
    input  logic [GLOB_ADDR_WIDTH-1:0]       bank0_dfx_ctrl_addr,
    input  logic [BANK0_INTR_WIDTH-1:0]      bank0_intr_ena,
    input  logic [BANK0_INTR_WIDTH-1:0]      bank0_intr,
    input  logic [BANK0_ROUNDTRIP_WIDTH-1:0] bank0_round_trip,
    input  logic [DATA_WIDTH-1:0]            bank1_rdata,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic [1:0]                       rresp,
    output logic                             bank1_hit
);

    logic [1:0] bank;
    logic [7:0] slot;
    logic [3:0] field;
    logic       unused;

    assign bank   = read_addr[15:14];
    assign slot   = read_addr[13:6];
    assign field  = read_addr[5:2];
    assign unused = &{1'b0, read_addr[1:0]};

    always_comb begin
        rdata     = '0;
        rresp     = RESP_SLVERR;
        bank1_hit = 1'b0;
        case (bank)
            BANK_SEL_0: begin
                rresp = RESP_OKAY;
                case (slot)
                    SLOT_CONTROL:    rdata = DATA_WIDTH'(bank0_control);
                    SLOT_STATUS:     rdata = DATA_WIDTH'(bank0_status);
                    SLOT_CNT:        rdata = DATA_WIDTH'(bank0_cnt);
                    SLOT_END_CNT:    rdata = DATA_WIDTH'(bank0_end_cnt);
                    SLOT_DMA_BASE:   rdata = DATA_WIDTH'(bank0_dma_base_addr);
                    SLOT_DFX_CTRL:   rdata = DATA_WIDTH'(bank0_dfx_ctrl_addr);
                    SLOT_INTR_ENA:   rdata = DATA_WIDTH'(bank0_intr_ena);
                    SLOT_INTR:       rdata = DATA_WIDTH'(bank0_intr);
                    SLOT_ROUND_TRIP: rdata = DATA_WIDTH'(bank0_round_trip);
                    default:         rresp = RESP_SLVERR;
                endcase
            end
            BANK_SEL_1: begin
                if (field <= FIELD_ST_INTR_MASK_ABS) begin
                    rdata     = bank1_rdata;
                    rresp     = RESP_OKAY;
                    bank1_hit = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/s_axi_read.sv
// AXI4-Lite read responder: one outstanding read, fixed four-cycle AR-to-ready turnaround.
module s_axi_read
    import s_axi_read_pkg::*;
#(
    parameter int GLOB_ADDR_WIDTH       = 32,
    parameter int ADDR_WIDTH            = 16,
    parameter int DATA_WIDTH            = 32,
    parameter int BANK1_INDEX_WIDTH     = 3,
    parameter int BANK0_CONTROL_WIDTH   = 4,
    parameter int BANK0_STATUS_WIDTH    = 4,
    parameter int BANK0_CNT_WIDTH       = BANK1_INDEX_WIDTH,
    parameter int BANK0_INTR_WIDTH      = 1,
    parameter int BANK0_ROUNDTRIP_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [ADDR_WIDTH-1:0]            S_AXI_ARADDR,
    input  logic                             S_AXI_ARVALID,
    output logic                             S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]            S_AXI_RDATA,
    output logic [1:0]                       S_AXI_RRESP,
    output logic                             S_AXI_RVALID,
    input  logic                             S_AXI_RREADY,
    output logic [BANK1_INDEX_WIDTH-1:0]     ext_bank1_out_index,
    output logic [3:0]                       ext_bank1_out_field,
    output logic                             ext_bank1_out_rd_en,
    input  logic [DATA_WIDTH-1:0]            ext_bank1_inp_rdata,
    input  logic [BANK0_CONTROL_WIDTH-1:0]   ext_bank0_inp_control,
    input  logic [BANK0_STATUS_WIDTH-1:0]    ext_bank0_inp_status,
    input  logic [BANK0_CNT_WIDTH-1:0]       ext_bank0_inp_cnt,
    input  logic [BANK0_CNT_WIDTH-1:0]       ext_bank0_inp_endCnt,
    input  logic [GLOB_ADDR_WIDTH-1:0]       ext_bank0_inp_dmaBaseAddr,
    input  logic [GLOB_ADDR_WIDTH-1:0]       ext_bank0_inp_dfxCtrlAddr,
    input  logic [BANK0_INTR_WIDTH-1:0]      ext_bank0_inp_intrEna,
    input  logic [BANK0_INTR_WIDTH-1:0]      ext_bank0_inp_intr,
    input  logic [BANK0_ROUNDTRIP_WIDTH-1:0] ext_bank0_inp_roundTrip
);

    read_state_t           state, state_next;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] rdata_q, dec_rdata;
    logic [1:0]            rresp_q, dec_rresp;
    logic                  bank1_hit;

    s_axi_read_decode #(
        .GLOB_ADDR_WIDTH       (GLOB_ADDR_WIDTH),
        .ADDR_WIDTH            (ADDR_WIDTH),
        .DATA_WIDTH            (DATA_WIDTH),
        .BANK0_CONTROL_WIDTH   (BANK0_CONTROL_WIDTH),
        .BANK0_STATUS_WIDTH    (BANK0_STATUS_WIDTH),
        .BANK0_CNT_WIDTH       (BANK0_CNT_WIDTH),
        .BANK0_INTR_WIDTH      (BANK0_INTR_WIDTH),
        .BANK0_ROUNDTRIP_WIDTH (BANK0_ROUNDTRIP_WIDTH)
    ) u_decode (
        .read_addr           (read_addr),
        .bank0_control       (ext_bank0_inp_control),
        .bank0_status        (ext_bank0_inp_status),
        .bank0_cnt           (ext_bank0_inp_cnt),
        .bank0_end_cnt       (ext_bank0_inp_endCnt),
        .bank0_dma_base_addr (ext_bank0_inp_dmaBaseAddr),
        .bank0_dfx_ctrl_addr (ext_bank0_inp_dfxCtrlAddr),
        .bank0_intr_ena      (ext_bank0_inp_intrEna),
        .bank0_intr          (ext_bank0_inp_intr),
        .bank0_round_trip    (ext_bank0_inp_roundTrip),
        .bank1_rdata         (ext_bank1_inp_rdata),
        .rdata               (dec_rdata),
        .rresp               (dec_rresp),
        .bank1_hit           (bank1_hit)
    );

    assign ext_bank1_out_index = read_addr[BANK1_INDEX_WIDTH+5:6];
    assign ext_bank1_out_field = read_addr[5:2];
    assign S_AXI_RDATA         = rdata_q;
    assign S_AXI_RRESP         = rresp_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next          = state;
        S_AXI_ARREADY       = 1'b0;
        S_AXI_RVALID        = 1'b0;
        ext_bank1_out_rd_en = 1'b0;
        case (state)
            ST_IDLE: begin
                S_AXI_ARREADY = 1'b1;
                if (S_AXI_ARVALID) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                ext_bank1_out_rd_en = bank1_hit;
                state_next          = ST_CAPT;
            end
            ST_CAPT: state_next = ST_RESP;
            ST_RESP: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Bank0 is sampled live in ST_CAPT, the same cycle the slot table presents its data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_addr <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            if (state == ST_IDLE && S_AXI_ARVALID) read_addr <= S_AXI_ARADDR;
            if (state == ST_CAPT) begin
                rdata_q <= dec_rdata;
                rresp_q <= dec_rresp;
            end
        end
    end

endmodule

// File: tb/tb_s_axi_read.sv
// Randomized bench for s_axi_read against a register-map reference model and slot-table model.
module tb_s_axi_read;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] S_AXI_ARADDR = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic [2:0]  ext_bank1_out_index;
    logic [3:0]  ext_bank1_out_field;
    logic        ext_bank1_out_rd_en;
    logic [31:0] ext_bank1_inp_rdata = '0;
    logic [3:0]  ext_bank0_inp_control = '0;
    logic [3:0]  ext_bank0_inp_status = '0;
    logic [2:0]  ext_bank0_inp_cnt = '0;
    logic [2:0]  ext_bank0_inp_endCnt = '0;
    logic [31:0] ext_bank0_inp_dmaBaseAddr = '0;
    logic [31:0] ext_bank0_inp_dfxCtrlAddr = '0;
    logic [0:0]  ext_bank0_inp_intrEna = '0;
    logic [0:0]  ext_bank0_inp_intr = '0;
    logic [15:0] ext_bank0_inp_roundTrip = '0;

    logic [31:0] mem [8][16];
    int          n_checks = 0;
    int          n_fail = 0;
    int          rd_pulses = 0;
    bit          pend = 0;
    int unsigned pidx = 0;
    int unsigned pfld = 0;

    always #5 clk = ~clk;

    s_axi_read #(
        .GLOB_ADDR_WIDTH       (32),
        .ADDR_WIDTH            (16),
        .DATA_WIDTH            (32),
        .BANK1_INDEX_WIDTH     (3),
        .BANK0_CONTROL_WIDTH   (4),
        .BANK0_STATUS_WIDTH    (4),
        .BANK0_CNT_WIDTH       (3),
        .BANK0_INTR_WIDTH      (1),
        .BANK0_ROUNDTRIP_WIDTH (16)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .S_AXI_ARADDR              (S_AXI_ARADDR),
        .S_AXI_ARVALID             (S_AXI_ARVALID),
        .S_AXI_ARREADY             (S_AXI_ARREADY),
        .S_AXI_RDATA               (S_AXI_RDATA),
        .S_AXI_RRESP               (S_AXI_RRESP),
        .S_AXI_RVALID              (S_AXI_RVALID),
        .S_AXI_RREADY              (S_AXI_RREADY),
        .ext_bank1_out_index       (ext_bank1_out_index),
        .ext_bank1_out_field       (ext_bank1_out_field),
        .ext_bank1_out_rd_en       (ext_bank1_out_rd_en),
        .ext_bank1_inp_rdata       (ext_bank1_inp_rdata),
        .ext_bank0_inp_control     (ext_bank0_inp_control),
        .ext_bank0_inp_status      (ext_bank0_inp_status),
        .ext_bank0_inp_cnt         (ext_bank0_inp_cnt),
        .ext_bank0_inp_endCnt      (ext_bank0_inp_endCnt),
        .ext_bank0_inp_dmaBaseAddr (ext_bank0_inp_dmaBaseAddr),
        .ext_bank0_inp_dfxCtrlAddr (ext_bank0_inp_dfxCtrlAddr),
        .ext_bank0_inp_intrEna     (ext_bank0_inp_intrEna),
        .ext_bank0_inp_intr        (ext_bank0_inp_intr),
        .ext_bank0_inp_roundTrip   (ext_bank0_inp_roundTrip)
    );

    // Slot table: registered read port, data valid only in the cycle after rd_en; garbage otherwise.
    always @(negedge clk) begin
        if (pend) begin
            ext_bank1_inp_rdata = mem[pidx][pfld];
            pend = 0;
        end else begin
            ext_bank1_inp_rdata = $urandom;
        end
        if (ext_bank1_out_rd_en) begin
            rd_pulses++;
            pend = 1;
            pidx = int'(ext_bank1_out_index);
            pfld = int'(ext_bank1_out_field);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic rand_bank0();
        ext_bank0_inp_control     = 4'($urandom);
        ext_bank0_inp_status      = 4'($urandom);
        ext_bank0_inp_cnt         = 3'($urandom);
        ext_bank0_inp_endCnt      = 3'($urandom);
        ext_bank0_inp_dmaBaseAddr = $urandom;
        ext_bank0_inp_dfxCtrlAddr = $urandom;
        ext_bank0_inp_intrEna     = 1'($urandom);
        ext_bank0_inp_intr        = 1'($urandom);
        ext_bank0_inp_roundTrip   = 16'($urandom);
    endtask

    function automatic void ref_read(input logic [15:0] a, output logic [31:0] d,
                                     output logic [1:0] r, output bit hit);
        int unsigned bank, slot, idx, fld;
        bank = int'(a) / 16384;
        slot = (int'(a) / 64) % 256;
        idx  = (int'(a) / 64) % 8;
        fld  = (int'(a) / 4) % 16;
        d = '0;
        r = 2'b10;
        hit = 0;
        if (bank == 0 && slot <= 8) begin
            r = 2'b00;
            case (slot)
                0: d = 32'(ext_bank0_inp_control);
                1: d = 32'(ext_bank0_inp_status);
                2: d = 32'(ext_bank0_inp_cnt);
                3: d = 32'(ext_bank0_inp_endCnt);
                4: d = ext_bank0_inp_dmaBaseAddr;
                5: d = ext_bank0_inp_dfxCtrlAddr;
                6: d = 32'(ext_bank0_inp_intrEna);
                7: d = 32'(ext_bank0_inp_intr);
                default: d = 32'(ext_bank0_inp_roundTrip);
            endcase
        end else if (bank == 1 && fld <= 8) begin
            hit = 1;
            r = 2'b00;
            d = mem[idx][fld];
        end
    endfunction

    // Caller sets bank0 values and the slot table before calling; they stay fixed for the read.
    task automatic do_read(input logic [15:0] a, input int unsigned hold, input bit early);
        logic [31:0] d;
        logic [1:0]  r;
        bit          hit;
        int unsigned waited;
        int          pulses0;
        @(negedge clk);
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = early;
        waited = 0;
        while (!S_AXI_ARREADY && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!S_AXI_ARREADY) begin
            check_eq("ar_timeout", 32'(S_AXI_ARREADY), 32'd1);
            S_AXI_ARVALID = 1'b0;
            return;
        end
        ref_read(a, d, r, hit);
        pulses0 = rd_pulses;
        @(negedge clk);
        S_AXI_ARVALID = 1'b0;
        S_AXI_ARADDR  = 16'($urandom);
        check_eq("rvalid_fetch", 32'(S_AXI_RVALID), 32'd0);
        check_eq("arready_fetch", 32'(S_AXI_ARREADY), 32'd0);
        check_eq("rden_fetch", 32'(ext_bank1_out_rd_en), 32'(hit));
        if (hit) begin
            check_eq("b1_index", 32'(ext_bank1_out_index), (int'(a) / 64) % 8);
            check_eq("b1_field", 32'(ext_bank1_out_field), (int'(a) / 4) % 16);
        end
        @(negedge clk);
        check_eq("rvalid_capt", 32'(S_AXI_RVALID), 32'd0);
        check_eq("rden_capt", 32'(ext_bank1_out_rd_en), 32'd0);
        @(negedge clk);
        check_eq("rvalid_resp", 32'(S_AXI_RVALID), 32'd1);
        check_eq("rdata", S_AXI_RDATA, d);
        check_eq("rresp", 32'(S_AXI_RRESP), 32'(r));
        check_eq("rden_pulses", 32'(rd_pulses - pulses0), 32'(hit));
        if (!early) begin
            for (int unsigned i = 0; i < hold; i++) begin
                S_AXI_ARVALID = 1'b1;
                S_AXI_ARADDR  = 16'h0104;
                @(negedge clk);
                check_eq("rvalid_hold", 32'(S_AXI_RVALID), 32'd1);
                check_eq("rdata_hold", S_AXI_RDATA, d);
                check_eq("rresp_hold", 32'(S_AXI_RRESP), 32'(r));
                check_eq("arready_hold", 32'(S_AXI_ARREADY), 32'd0);
            end
            S_AXI_ARVALID = 1'b0;
            S_AXI_RREADY  = 1'b1;
        end
        @(negedge clk);
        check_eq("rvalid_done", 32'(S_AXI_RVALID), 32'd0);
        check_eq("arready_done", 32'(S_AXI_ARREADY), 32'd1);
        S_AXI_RREADY = 1'b0;
    endtask

    function automatic logic [15:0] rand_addr();
        int unsigned kind;
        logic [15:0] a;
        kind = $urandom_range(0, 3);
        case (kind)
            0, 1: a = 16'(($urandom_range(0, 10) * 64) + $urandom_range(0, 63));
            2:    a = 16'(16384 + ($urandom_range(0, 31) * 512) + ($urandom_range(0, 7) * 64)
                      + ($urandom_range(0, 15) * 4) + $urandom_range(0, 3));
            default: a = 16'(32768 + $urandom_range(0, 32767));
        endcase
        return a;
    endfunction

    initial begin
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 16; j++)
                mem[i][j] = $urandom;

        repeat (2) @(negedge clk);
        check_eq("rst_arready", 32'(S_AXI_ARREADY), 32'd1);
        check_eq("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
        check_eq("rst_rdata", S_AXI_RDATA, 32'd0);
        check_eq("rst_rresp", 32'(S_AXI_RRESP), 32'd0);
        check_eq("rst_rden", 32'(ext_bank1_out_rd_en), 32'd0);
        reset = 1'b1;

        rand_bank0();
        ext_bank0_inp_dmaBaseAddr = 32'hA000_0000;
        do_read(16'h0104, 0, 1'b1);
        mem[2][2] = 32'h1234_5678;
        do_read(16'h4288, 0, 1'b0);
        ext_bank0_inp_roundTrip = 16'hBEEF;
        do_read(16'h0200, 0, 1'b1);
        do_read(16'h8000, 0, 1'b1);
        do_read(16'h4024, 0, 1'b0);
        do_read(16'h0240, 0, 1'b1);
        do_read(16'hC000, 0, 1'b0);
        rand_bank0();
        do_read(16'h0040, 10, 1'b0);

        // Reset while the response is pending.
        @(negedge clk);
        S_AXI_ARADDR  = 16'h0200;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b0;
        @(negedge clk);
        S_AXI_ARVALID = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("midrst_pre_rvalid", 32'(S_AXI_RVALID), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("midrst_rvalid", 32'(S_AXI_RVALID), 32'd0);
        check_eq("midrst_arready", 32'(S_AXI_ARREADY), 32'd1);
        check_eq("midrst_rdata", S_AXI_RDATA, 32'd0);
        check_eq("midrst_rresp", 32'(S_AXI_RRESP), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        rand_bank0();
        do_read(16'h4000 + 16'h01C0 + 16'h0020, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            rand_bank0();
            do_read(rand_addr(), $urandom_range(0, 3), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/s_axi_read.md
# s_axi_read

AXI4-Lite read-channel responder for the sequencer's control block; the read-side counterpart of the existing write responder over the same 16-bit register map. It accepts one read at a time, decodes the address into the bank0 control/status registers or a bank1 slot-table field, fetches the value, and returns it on the R channel. The slot table has a one-cycle registered read port. Bank0 values are sampled directly from live register outputs.

## Interface
- GLOB_ADDR_WIDTH, 32, width of the DMA and DFX base-address registers
- ADDR_WIDTH, 16, AXI-Lite address width
- DATA_WIDTH, 32, AXI-Lite data width
- BANK1_INDEX_WIDTH, 3, slot-index width
- BANK0_CONTROL_WIDTH, 4, control register width
- BANK0_STATUS_WIDTH, 4, status register width
- BANK0_CNT_WIDTH, BANK1_INDEX_WIDTH, width of the current and end counters
- BANK0_INTR_WIDTH, 1, width of the interrupt enable and interrupt registers
- BANK0_ROUNDTRIP_WIDTH, 16, round-trip counter width

Clock and reset (already decided): one clock, `clk`; reset `reset` is asynchronous and active-low.

- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- S_AXI_ARADDR  in  ADDR_WIDTH  read address
- S_AXI_ARVALID  in  1  address valid
- S_AXI_ARREADY  out  1  address ready
- S_AXI_RDATA  out  DATA_WIDTH  read data
- S_AXI_RRESP  out  2  00 = OKAY, 10 = SLVERR
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  master ready
- ext_bank1_out_index  out  BANK1_INDEX_WIDTH  slot row to read
- ext_bank1_out_field  out  4  field select (0 src_addr … 8 st_intr_mask_abs)
- ext_bank1_out_rd_en  out  1  slot-table read strobe
- ext_bank1_inp_rdata  in  DATA_WIDTH  field value, already zero-extended; valid the cycle after rd_en
- ext_bank0_inp_control  in  BANK0_CONTROL_WIDTH  control register
- ext_bank0_inp_status  in  BANK0_STATUS_WIDTH  status register
- ext_bank0_inp_cnt  in  BANK0_CNT_WIDTH  current sequencer counter
- ext_bank0_inp_endCnt  in  BANK0_CNT_WIDTH  end count
- ext_bank0_inp_dmaBaseAddr  in  GLOB_ADDR_WIDTH  DMA base address
- ext_bank0_inp_dfxCtrlAddr  in  GLOB_ADDR_WIDTH  DFX controller address
- ext_bank0_inp_intrEna  in  BANK0_INTR_WIDTH  interrupt enable
- ext_bank0_inp_intr  in  BANK0_INTR_WIDTH  interrupt flag
- ext_bank0_inp_roundTrip  in  BANK0_ROUNDTRIP_WIDTH  round-trip counter

## Operation
- FSM states:
  - ST_IDLE: ARREADY=1. On ARVALID, latch ARADDR into read_addr → ST_FETCH.
  - ST_FETCH: for bank1 addresses, assert rd_en → ST_CAPT unconditionally.
  - ST_CAPT: register the decoded data and response into rdata_q / rresp_q → ST_RESP.
  - ST_RESP: RVALID=1; hold RDATA/RRESP stable. On RREADY → ST_IDLE.
  - Any illegal state value → ST_IDLE.
- Bank decode (read_addr[15:14]):
  - 00 = bank0; slot is read_addr[13:6]:
    - 00 control, 01 status, 02 cnt, 03 endCnt, 04 dmaBaseAddr
    - 05 dfxCtrlAddr, 06 intrEna, 07 intr, 08 roundTrip
  - 01 = bank1; index = read_addr[BANK1_INDEX_WIDTH+5:6], field = read_addr[5:2].
  - Field values 0–8 are mapped; 9–15 are unmapped.
- Bank0 values are sampled in ST_CAPT and zero-extended to DATA_WIDTH.
- Unmapped address (bank 10/11, bank0 slot >08, bank1 field >8): RDATA=0, RRESP=SLVERR, rd_en not asserted.
- ext_bank1_out_index / ext_bank1_out_field are driven from read_addr continuously; rd_en is the only qualifier.
- Reads have no side effects. Read-to-clear is not supported.

## Timing
- Reset values: state=ST_IDLE, read_addr=0, rdata_q=0, rresp_q=00.
- Reset outputs: ARREADY=1, RVALID=0, RDATA=0, RRESP=00, rd_en=0.
- AR handshake at edge N → RVALID first high in cycle N+3.
- With RREADY already high, ARREADY returns in cycle N+4. Peak throughput is one read per 4 cycles.
- ARVALID arriving during ST_FETCH/CAPT/RESP is not accepted (ARREADY=0) and is held by the master.
- RREADY low: RVALID, RDATA and RRESP stay constant indefinitely.
- RREADY high before RVALID has no effect.
- The write responder runs independently. A read and a write to the same register in the same cycle returns the pre-write value for bank0; bank1 returns whatever the slot table presents.
- Reset asserted mid-transaction: immediate return to reset values; the in-flight response is dropped.

## Structure
- Shared package holds:
  - Bank select codes (00/01).
  - Bank0 slot codes 00–08.
  - Bank1 field codes 0–8.
  - RRESP constants OKAY / SLVERR.
  - FSM state encodings.
- The write responder uses the same package.
- One natural sub-module: `s_axi_read_decode`, combinational: read_addr + bank0 inputs + bank1 rdata → {rdata, rresp, bank1_hit}.

## Test plan
- After reset, read 0x0104 (bank0 slot 04) with dmaBaseAddr=0xA000_0000 → RDATA=0xA000_0000, RRESP=00, RVALID high exactly 3 cycles after the AR handshake.
- Read 0x4288 (bank1, index 2, field 2) with a slot-table model returning 0x1234_5678 → index=2, field=2, rd_en one pulse in ST_FETCH, RDATA=0x1234_5678.
- Read 0x0200 (bank0 slot 08) with roundTrip=0xBEEF → RDATA=0x0000_BEEF, upper bits zero.
- Read 0x8000 and 0x4024 (field 9) → RDATA=0, RRESP=10, rd_en never asserted.
- Hold RREADY low for 10 cycles → RVALID/RDATA stable and ARREADY=0 throughout; ARVALID presented meanwhile is accepted only after the R handshake.
- Assert reset while in ST_RESP → RVALID=0 and ARREADY=1 immediately; a new read after release completes normally.
